rom_burst_reader: RTL and testbench

//  Read sequencer in front of the synchronous rom (rd_en/cs/addr/data). Accepts a burst request,

---
 rtl/rom_rd_pkg.sv | 18 +
 rtl/rom_burst_reader_if.sv | 31 +++
 rtl/rom_rd_fifo.sv | 59 +++++
 rtl/rom_burst_reader.sv | 147 ++++++++++++++
 tb/tb_rom_burst_reader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_rd_pkg.sv
// Shared types and sizing helpers for the ROM burst reader.
package rom_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int FIFO_DEPTH_DEFAULT = 4;
   localparam int CREDIT_W_DEFAULT   = $clog2(FIFO_DEPTH_DEFAULT + 1);

   // Counter width able to hold every value from 0 to depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request, ROM-port and output-stream signals of the ROM burst reader.
interface rom_burst_reader_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_len;
   logic              rom_cs;
   logic              rom_rd_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;

   modport slave (
      input  req_valid, req_addr, req_len, rom_data, out_ready,
      output req_ready, rom_cs, rom_rd_en, rom_addr, out_valid, out_data, out_last, busy
   );

   modport master (
      output req_valid, req_addr, req_len, rom_data, out_ready,
      input  req_ready, rom_cs, rom_rd_en, rom_addr, out_valid, out_data, out_last, busy
   );

endinterface

// File: rtl/rom_rd_fifo.sv
// Registered synchronous FIFO holding {last, data} words for the output stream.
module rom_rd_fifo
   import rom_rd_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push_i,
   input  logic [WIDTH-1:0]                data_i,
   input  logic                            pop_i,
   output logic [WIDTH-1:0]                data_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [credit_width(DEPTH)-1:0] count_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = credit_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign data_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read sequencer: issues one ROM read per credit and streams the words out through a FIFO.
module rom_burst_reader
   import rom_rd_pkg::*;
#(
   parameter int ADDR_W     = 2,
   parameter int DATA_W     = 4,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   rom_burst_reader_if.slave  bus
);

   localparam int CNT_W = credit_width(FIFO_DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] curAddr_q, curAddr_d;
   logic [ADDR_W-1:0] remLen_q, remLen_d;
   logic [ADDR_W-1:0] romAddr_q, romAddr_d;
   logic              romCs_q, romCs_d;
   logic              issueLast_q, issueLast_d;
   logic [RD_LAT-1:0] pipeValid_q;
   logic [RD_LAT-1:0] pipeLast_q;

   logic              fifoPush;
   logic              fifoPop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [CNT_W-1:0]  fifoCount;
   logic [DATA_W:0]   fifoDin;
   logic [DATA_W:0]   fifoDout;

   int                inflight;
   logic              credit;

   // Words already issued but not yet in the FIFO still own a FIFO slot.
   always_comb begin
      inflight = int'(romCs_q);
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + int'(pipeValid_q[i]);
      end
      credit = (int'(fifoCount) + inflight) < FIFO_DEPTH;
   end

   always_comb begin
      state_d     = state_q;
      curAddr_d   = curAddr_q;
      remLen_d    = remLen_q;
      romCs_d     = 1'b0;
      romAddr_d   = romAddr_q;
      issueLast_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               curAddr_d = bus.req_addr;
               remLen_d  = bus.req_len;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (credit) begin
               romCs_d     = 1'b1;
               romAddr_d   = curAddr_q;
               issueLast_d = (remLen_q == '0);
               curAddr_d   = curAddr_q + 1'b1;
               remLen_d    = remLen_q - 1'b1;
               if (remLen_q == '0) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifoPop && fifoDout[DATA_W]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         curAddr_q   <= '0;
         remLen_q    <= '0;
         romAddr_q   <= '0;
         romCs_q     <= 1'b0;
         issueLast_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         curAddr_q   <= curAddr_d;
         remLen_q    <= remLen_d;
         romAddr_q   <= romAddr_d;
         romCs_q     <= romCs_d;
         issueLast_q <= issueLast_d;
      end
   end

   // Delay line matching the ROM read latency so the tag lines up with rom_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipeValid_q <= '0;
         pipeLast_q  <= '0;
      end else begin
         pipeValid_q[0] <= romCs_q;
         pipeLast_q[0]  <= issueLast_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipeValid_q[i] <= pipeValid_q[i-1];
            pipeLast_q[i]  <= pipeLast_q[i-1];
         end
      end
   end

   assign fifoPush = pipeValid_q[RD_LAT-1];
   assign fifoDin  = {pipeLast_q[RD_LAT-1], bus.rom_data};
   assign fifoPop  = !fifoEmpty && bus.out_ready;

   rom_rd_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifoPush),
      .data_i  (fifoDin),
      .pop_i   (fifoPop),
      .data_o  (fifoDout),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rom_cs    = romCs_q;
   assign bus.rom_rd_en = romCs_q;
   assign bus.rom_addr  = romAddr_q;
   assign bus.out_valid = !fifoEmpty;
   assign bus.out_data  = fifoDout[DATA_W-1:0];
   assign bus.out_last  = fifoDout[DATA_W];

   noOverflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifoPush && fifoFull));

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: ROM models, a burst-level reference queue and per-scenario tasks.
module tb_rom_burst_reader;

   localparam int ADDR_W   = 2;
   localparam int DATA_W   = 4;
   localparam int RD_LAT   = 1;
   localparam int ROM_SIZE = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] romA [ROM_SIZE];
   logic [DATA_W-1:0] romB [ROM_SIZE];
   logic [DATA_W:0]   expQ [$];

   rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   rom_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) smBus ();

   rom_burst_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   rom_burst_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(2)
   ) dutSmall (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (smBus)
   );

   always #5 clk = ~clk;

   // ROM models: one read latency after cs&rd_en is sampled.
   always @(posedge clk) begin
      if (bus.rom_cs && bus.rom_rd_en) bus.rom_data <= romA[bus.rom_addr];
      if (smBus.rom_cs && smBus.rom_rd_en) smBus.rom_data <= romB[smBus.rom_addr];
   end

   // Reference model for the main reader: each accepted burst expands into its word list.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req_valid && bus.req_ready) begin
            checks++;
            if (expQ.size() != 0) begin
               errors++;
               $display("[TB] FAIL burst_overlap: got %0d words outstanding at accept, expected 0", expQ.size());
            end
            for (int i = 0; i <= int'(bus.req_len); i++) begin
               expQ.push_back({(i == int'(bus.req_len)), romA[(int'(bus.req_addr) + i) % ROM_SIZE]});
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL stream_extra: got word %0h with nothing expected", {bus.out_last, bus.out_data});
            end else begin
               logic [DATA_W:0] exp;
               exp = expQ.pop_front();
               if ({bus.out_last, bus.out_data} !== exp) begin
                  errors++;
                  $display("[TB] FAIL stream_word: got {last,data}=%0h expected %0h", {bus.out_last, bus.out_data}, exp);
               end
            end
         end
      end
   end

   task automatic sendAccept(input int addr, input int len);
      bus.req_valid = 1'b1;
      bus.req_addr  = ADDR_W'(addr);
      bus.req_len   = ADDR_W'(len);
      for (int i = 0; i < 20 && !bus.req_ready; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL accept_timeout: got req_ready=%b expected 1", bus.req_ready);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rom_cs, bus.rom_rd_en, bus.rom_addr, bus.out_valid, bus.busy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_main: got cs/rd/addr/valid/busy=%0h expected 0",
                  {bus.rom_cs, bus.rom_rd_en, bus.rom_addr, bus.out_valid, bus.busy});
      end
      checks++;
      if ({smBus.rom_cs, smBus.rom_rd_en, smBus.rom_addr, smBus.out_valid, smBus.busy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_small: got cs/rd/addr/valid/busy=%0h expected 0",
                  {smBus.rom_cs, smBus.rom_rd_en, smBus.rom_addr, smBus.out_valid, smBus.busy});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.req_ready !== 1'b1 || smBus.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b/%b expected 1/1", bus.req_ready, smBus.req_ready);
      end
   endtask

   // Unstalled burst: cycle-exact ROM port, stream and busy timing.
   task automatic test_burst(input int addr, input int len);
      sendAccept(addr, len);
      for (int k = 1; k <= len + 4; k++) begin
         logic              expCs;
         logic [ADDR_W-1:0] expAddr;
         logic              expValid;
         logic              expBusy;
         @(posedge clk); #1;
         expCs    = (k <= len + 1);
         expAddr  = expCs ? ADDR_W'((addr + k - 1) % ROM_SIZE) : ADDR_W'((addr + len) % ROM_SIZE);
         expValid = (k >= 3) && (k <= len + 3);
         expBusy  = (k <= len + 3);
         checks++;
         if (bus.rom_cs !== expCs || bus.rom_rd_en !== expCs || bus.rom_addr !== expAddr) begin
            errors++;
            $display("[TB] FAIL rom_port k=%0d: got cs=%b rd=%b addr=%0d expected cs=%b addr=%0d",
                     k, bus.rom_cs, bus.rom_rd_en, bus.rom_addr, expCs, expAddr);
         end
         checks++;
         if (bus.out_valid !== expValid) begin
            errors++;
            $display("[TB] FAIL out_valid k=%0d: got %b expected %b", k, bus.out_valid, expValid);
         end else if (expValid) begin
            checks++;
            if (bus.out_data !== romA[(addr + k - 3) % ROM_SIZE] || bus.out_last !== (k == len + 3)) begin
               errors++;
               $display("[TB] FAIL out_word k=%0d: got data=%0h last=%b expected data=%0h last=%b", k,
                        bus.out_data, bus.out_last, romA[(addr + k - 3) % ROM_SIZE], (k == len + 3));
            end
         end
         checks++;
         if (bus.busy !== expBusy || bus.req_ready !== !expBusy) begin
            errors++;
            $display("[TB] FAIL busy k=%0d: got busy=%b ready=%b expected busy=%b", k, bus.busy, bus.req_ready, expBusy);
         end
      end
   endtask

   task automatic test_backpressure();
      int csCount;
      int nGot;
      smBus.out_ready = 1'b0;
      smBus.req_valid = 1'b1;
      smBus.req_addr  = '0;
      smBus.req_len   = 2'd3;
      @(posedge clk); #1;
      smBus.req_valid = 1'b0;
      csCount = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (smBus.rom_cs) csCount++;
      end
      checks++;
      if (csCount != 2) begin
         errors++;
         $display("[TB] FAIL stall_issues: got %0d rom_cs cycles expected 2", csCount);
      end
      checks++;
      if (smBus.out_valid !== 1'b1 || smBus.out_data !== romB[0]) begin
         errors++;
         $display("[TB] FAIL stall_head: got valid=%b data=%0h expected 1/%0h", smBus.out_valid, smBus.out_data, romB[0]);
      end
      smBus.out_ready = 1'b1;
      csCount = 0;
      nGot    = 0;
      for (int k = 0; k < 25; k++) begin
         if (smBus.rom_cs) csCount++;
         if (smBus.out_valid && smBus.out_ready) begin
            checks++;
            if (nGot >= ROM_SIZE) begin
               errors++;
               $display("[TB] FAIL stall_extra: got word %0h after 4 words, expected none", smBus.out_data);
            end else if (smBus.out_data !== romB[nGot] || smBus.out_last !== (nGot == 3)) begin
               errors++;
               $display("[TB] FAIL stall_word%0d: got data=%0h last=%b expected data=%0h last=%b",
                        nGot, smBus.out_data, smBus.out_last, romB[nGot], (nGot == 3));
            end
            nGot++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (csCount != 2 || nGot != 4 || smBus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_release: got issues=%0d words=%0d busy=%b expected 2/4/0", csCount, nGot, smBus.busy);
      end
   endtask

   task automatic test_reset_mid_burst();
      sendAccept(0, 3);
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.rom_cs !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset: got valid=%b cs=%b expected 1/1", bus.out_valid, bus.rom_cs);
      end
      rst_n = 1'b0;
      expQ.delete();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.rom_cs !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got valid=%b cs=%b busy=%b expected 0/0/0", bus.out_valid, bus.rom_cs, bus.busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b0 || bus.rom_cs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stale_word k=%0d: got valid=%b cs=%b expected 0/0", k, bus.out_valid, bus.rom_cs);
         end
      end
      test_burst(1, 1);
   endtask

   // Request held high across bursts with a randomly stalling consumer.
   task automatic test_held_request();
      int  bursts = 0;
      bit  accPending = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = ADDR_W'($urandom_range(0, 3));
      bus.req_len   = ADDR_W'($urandom_range(0, 3));
      for (int cyc = 0; cyc < 600 && bursts < 6; cyc++) begin
         @(posedge clk); #1;
         if (accPending) begin
            bus.req_addr = ADDR_W'($urandom_range(0, 3));
            bus.req_len  = ADDR_W'($urandom_range(0, 3));
            bursts++;
            accPending = 1'b0;
         end
         bus.out_ready = 1'($urandom_range(0, 1));
         if (bus.req_ready) accPending = 1'b1;
      end
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (bursts < 6) begin
         errors++;
         $display("[TB] FAIL held_bursts: got %0d bursts accepted expected 6", bursts);
      end
      for (int k = 0; k < 60 && (bus.busy || expQ.size() != 0); k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bus.busy !== 1'b0 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL held_drain: got busy=%b pending=%0d expected 0/0", bus.busy, expQ.size());
      end
   endtask

   initial begin
      for (int i = 0; i < ROM_SIZE; i++) begin
         romA[i] = DATA_W'($urandom);
         romB[i] = DATA_W'($urandom);
      end
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_len     = '0;
      bus.out_ready   = 1'b1;
      bus.rom_data    = '0;
      smBus.req_valid = 1'b0;
      smBus.req_addr  = '0;
      smBus.req_len   = '0;
      smBus.out_ready = 1'b1;
      smBus.rom_data  = '0;

      test_reset();
      test_burst(0, 3);
      test_burst(2, 3);
      test_backpressure();
      test_burst(1, 0);
      test_reset_mid_burst();
      test_held_request();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
